type_decode_queue: RTL and testbench
====================================

// Module: type_decode_queue
// PURPOSE
//  Registered, parametrised RV32 instruction-type decoder with an elastic output queue.
//  Accepts instructions over valid/ready and classifies each into one-hot type
//  (R,I,L,Jr,S,Sb,aui,lui,J), extracting fields and a sign-extended immediate.
//  Holds up to DEPTH decoded entries in order; sits between fetch and issue/execute.
// PARAMETERS
//  XLEN   32  immediate/pc width; >=32; immediates sign-extended from bit 31 of source
//  DEPTH  2   decoded-entry queue depth; power of two, >=2
// PORTS
//  clk          in   1        clock
//  reset        in   1        synchronous active-high reset
//  flush        in   1        discard all queued entries
//  in_valid     in   1        instruction offered
//  in_ready     out  1        queue can accept this cycle
//  in_instr     in   32       raw instruction word
//  in_pc        in   XLEN     instruction address
//  out_valid    out  1        head entry valid
//  out_ready    in   1        consumer takes head
//  out_type     out  9        one-hot: [0]R [1]I [2]L [3]Jr [4]S [5]Sb [6]aui [7]lui [8]J
//  out_imm      out  XLEN     sign-extended immediate (0 for R/unknown)
//  out_rd/rs1/rs2 out 5 each  register fields instr[11:7]/[19:15]/[24:20]
//  out_funct3   out  3        instr[14:12]
//  out_funct7   out  7        instr[31:25]
//  out_pc       out  XLEN     pc of head entry
//  count        out  $clog2(DEPTH)+1  entries held
// BEHAVIOUR
//  - Reset (sync, active-high): count=0, pointers=0, out_valid=0; in_ready=1 next cycle.
//  - Opcodes: R 0110011, I 0010011, L 0000011, Jr 1100111, S 0100011, Sb 1100011,
//    aui 0010111, lui 0110111, J 1101111; any other -> out_type=0, out_imm=0.
//  - Imm: I/L/Jr {instr[31:20]}; S {[31:25],[11:7]}; Sb {[31],[7],[30:25],[11:8],0};
//    aui/lui {[31:12],12'b0}; J {[31],[19:12],[20],[30:21],0}; all sign-extend to XLEN.
//  - Decode happens at push; entries stored already decoded; outputs driven from head
//    entry registers (no comb path in_* -> out_*).
//  - Push when in_valid&&in_ready; pop when out_valid&&out_ready.
//  - in_ready = (count<DEPTH), registered-count based; no in_ready<-out_ready comb path.
//  - Latency: push in cycle N into empty queue -> out_valid=1 in cycle N+1.
//  - Simultaneous push+pop (count<DEPTH): count unchanged, order preserved.
//  - Full: in_ready=0, in_valid ignored. Empty: out_valid=0, out_* hold last values.
//  - Pointers wrap modulo DEPTH.
//  - flush: next cycle count=0, out_valid=0; concurrent push and pop discarded.
//    reset has priority over flush; reset mid-stream drops all entries.
//  - out_* stable while out_valid&&!out_ready.
// CONFIGURATION
//  ILLEGAL_OPCODE_EN defined: adds port out_illegal (out,1) = head opcode unrecognised
//    or instr[1:0]!=2'b11; entry still queued, out_type=0.
//  Undefined: no out_illegal port; unknown opcodes pass silently with out_type=0.
// STRUCTURE
//  Package type_decode_pkg: opcode localparams, type-index enum (R..J, 0..8),
//    packed struct decoded_t {type,imm,rd,rs1,rs2,funct3,funct7,pc[,illegal]}.
//  Sub-module imm_gen (combinational: instr,type -> imm); queue storage inline.
// TESTING
//  1 reset high 2 cycles -> out_valid=0, in_ready=1, count=0.
//  2 push 0x00500093 pc=0x100, out_ready=1 -> next cycle out_valid=1,
//    out_type=9'b000000010, out_imm=5, rd=1, rs1=0, out_pc=0x100; count back to 0 after pop.
//  3 push 0xFE000EE3 (beq -4) then 0x12345037 (lui) -> out_type 9'b000100000 imm
//    0xFFFFFFFC; then out_type 9'b010000000 imm 0x12345000, in order.
//  4 out_ready=0, push DEPTH+1 instrs -> in_ready=0 after DEPTH, count=DEPTH,
//    extra dropped; release out_ready -> entries drain in push order.
//  5 push 0x0000000F -> out_type=0, out_imm=0; with ILLEGAL_OPCODE_EN out_illegal=1.
//  6 queue holding 2, assert flush with in_valid=1 -> next cycle count=0,
//    out_valid=0, pushed instr not present.

Source files
------------

// File: rtl/type_decode_pkg.sv
// Shared definitions for the RV32 type-decode queue.
// Holds the opcode constants, the type-index enum that fixes the bit order
// of the one-hot type vector, the width-independent decoded fields, and the
// opcode-to-type classifier.
// Configuration: ILLEGAL_OPCODE_EN adds an illegal flag to decoded_t.
package type_decode_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_L   = 7'b0000011;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_SB  = 7'b1100011;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_J   = 7'b1101111;

  localparam int NTYPES = 9;

  typedef enum logic [3:0] {
    T_R   = 4'd0,
    T_I   = 4'd1,
    T_L   = 4'd2,
    T_JR  = 4'd3,
    T_S   = 4'd4,
    T_SB  = 4'd5,
    T_AUI = 4'd6,
    T_LUI = 4'd7,
    T_J   = 4'd8
  } type_idx_e;

  // Fields that do not depend on XLEN; imm and pc are added by the queue.
  typedef struct packed {
    logic [NTYPES-1:0] itype;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
`ifdef ILLEGAL_OPCODE_EN
    logic              illegal;
`endif
  } decoded_t;

  // One-hot classification; unrecognised opcodes yield all zeros.
  function automatic logic [NTYPES-1:0] decode_type(input logic [6:0] opcode);
    logic [NTYPES-1:0] t;
    t = '0;
    case (opcode)
      OP_R:    t[T_R]   = 1'b1;
      OP_I:    t[T_I]   = 1'b1;
      OP_L:    t[T_L]   = 1'b1;
      OP_JR:   t[T_JR]  = 1'b1;
      OP_S:    t[T_S]   = 1'b1;
      OP_SB:   t[T_SB]  = 1'b1;
      OP_AUI:  t[T_AUI] = 1'b1;
      OP_LUI:  t[T_LUI] = 1'b1;
      OP_J:    t[T_J]   = 1'b1;
      default: t = '0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/type_decode_queue_if.sv
// Bus interface for type_decode_queue.
// Input side: flush, in_valid/in_ready, in_instr, in_pc.
// Output side: out_valid/out_ready, out_type, out_imm, out_rd/rs1/rs2,
// out_funct3, out_funct7, out_pc, count (and out_illegal when
// ILLEGAL_OPCODE_EN is defined).
// master = producer/consumer side, slave = the queue.
interface type_decode_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [8:0]      out_type;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_pc;
  logic [CW-1:0]   count;
`ifdef ILLEGAL_OPCODE_EN
  logic            out_illegal;
`endif

  modport master (
`ifdef ILLEGAL_OPCODE_EN
    input  out_illegal,
`endif
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_type, out_imm, out_rd, out_rs1, out_rs2,
    input  out_funct3, out_funct7, out_pc, count
  );

  modport slave (
`ifdef ILLEGAL_OPCODE_EN
    output out_illegal,
`endif
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_type, out_imm, out_rd, out_rs1, out_rs2,
    output out_funct3, out_funct7, out_pc, count
  );
endinterface

// File: rtl/type_decode_queue_imm_gen.sv
// imm_gen: combinational immediate builder.
// Ports: instr_hi (instr[31:7]; the opcode is already folded into itype),
// itype (one-hot type), imm (immediate sign-extended from bit 31 to XLEN;
// zero for R-type and unknown opcodes).
module imm_gen
  import type_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]        instr_hi,
  input  logic [NTYPES-1:0]  itype,
  output logic signed [XLEN-1:0] imm
);
  logic [31:0]        instr;
  logic signed [31:0] imm32;

  assign instr = {instr_hi, 7'b0};

  always_comb begin
    imm32 = '0;
    if (itype[T_I] || itype[T_L] || itype[T_JR])
      imm32 = {{20{instr[31]}}, instr[31:20]};
    else if (itype[T_S])
      imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    else if (itype[T_SB])
      imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    else if (itype[T_AUI] || itype[T_LUI])
      imm32 = {instr[31:12], 12'b0};
    else if (itype[T_J])
      imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  end

  // Signed cast widens with sign extension for XLEN > 32.
  assign imm = XLEN'(imm32);
endmodule

// File: rtl/type_decode_queue.sv
// type_decode_queue: registered RV32 instruction-type decoder with an
// in-order queue of DEPTH decoded entries.
// Ports: clk, reset (sync, active-high), bus (type_decode_queue_if.slave:
// flush, in_* valid/ready input, out_* decoded head entry, count).
// Instructions are decoded at push and stored decoded; the outputs come
// straight from queue storage, so there is no combinational in_* -> out_*
// path and in_ready depends only on the registered count.
// Configuration: ILLEGAL_OPCODE_EN adds bus.out_illegal.
module type_decode_queue
  import type_decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input logic              clk,
  input logic              reset,
  type_decode_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef struct packed {
    decoded_t               f;
    logic signed [XLEN-1:0] imm;
    logic [XLEN-1:0]        pc;
  } entry_t;

  entry_t                 mem [DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr, show_ptr;
  logic [AW:0]            count_r;
  decoded_t               dec;
  logic signed [XLEN-1:0] dec_imm;
  logic                   push, pop;
  entry_t                 head;

  always_comb begin
    dec        = '0;
    dec.itype  = decode_type(bus.in_instr[6:0]);
    dec.rd     = bus.in_instr[11:7];
    dec.funct3 = bus.in_instr[14:12];
    dec.rs1    = bus.in_instr[19:15];
    dec.rs2    = bus.in_instr[24:20];
    dec.funct7 = bus.in_instr[31:25];
`ifdef ILLEGAL_OPCODE_EN
    dec.illegal = (dec.itype == '0) || (bus.in_instr[1:0] != 2'b11);
`endif
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_hi (bus.in_instr[31:7]),
    .itype    (dec.itype),
    .imm      (dec_imm)
  );

  assign bus.in_ready  = (count_r < DEPTH_C);
  assign bus.out_valid = (count_r != '0);
  // A flush swallows any push offered in the same cycle.
  assign push = bus.in_valid && bus.in_ready && !bus.flush;
  assign pop  = bus.out_valid && bus.out_ready;

  // Storage write: data only, no reset.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{f: dec, imm: dec_imm, pc: bus.in_pc};
  end

  // Control: pointers and occupancy. Reset beats flush.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // When empty, keep presenting the most recently popped slot so the
  // outputs hold their last values; a push into an empty queue writes
  // rd_ptr, never rd_ptr-1, so that slot stays intact.
  assign show_ptr = (count_r == '0) ? (rd_ptr - 1'b1) : rd_ptr;
  assign head     = mem[show_ptr];

  assign bus.out_type   = head.f.itype;
  assign bus.out_imm    = head.imm;
  assign bus.out_rd     = head.f.rd;
  assign bus.out_rs1    = head.f.rs1;
  assign bus.out_rs2    = head.f.rs2;
  assign bus.out_funct3 = head.f.funct3;
  assign bus.out_funct7 = head.f.funct7;
  assign bus.out_pc     = head.pc;
  assign bus.count      = count_r;
`ifdef ILLEGAL_OPCODE_EN
  assign bus.out_illegal = head.f.illegal;
`endif
endmodule

// File: tb/tb_type_decode_queue.sv
// Directed bench for type_decode_queue (XLEN=32, DEPTH=2).
module tb_type_decode_queue;
  import type_decode_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic clk;
  logic reset;
  int   checks;
  int   passed;

  type_decode_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  type_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi(input logic [11:0] imm, input logic [4:0] rd);
    return {imm, 5'd0, 3'd0, rd, 7'b0010011};
  endfunction

  initial begin
    checks = 0;
    passed = 0;
    reset = 1'b1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.in_pc = '0;
    bus.out_ready = 1'b0;

    // 1: reset
    step();
    step();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_count", bus.count, 0);
    reset = 1'b0;
    step();
    chk("rst_in_ready", bus.in_ready, 1);

    // 2: addi x1, x0, 5
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h00500093;
    bus.in_pc = 32'h100;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("addi_valid", bus.out_valid, 1);
    chk("addi_type", bus.out_type, 9'b000000010);
    chk("addi_imm", bus.out_imm, 5);
    chk("addi_rd", bus.out_rd, 1);
    chk("addi_rs1", bus.out_rs1, 0);
    chk("addi_pc", bus.out_pc, 32'h100);
    chk("addi_count", bus.count, 1);
    step();
    chk("addi_count_after_pop", bus.count, 0);
    chk("addi_valid_after_pop", bus.out_valid, 0);
    chk("empty_hold_imm", bus.out_imm, 5);

    // 3: beq -4 then lui, order preserved
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'hFE000EE3;
    bus.in_pc = 32'h200;
    step();
    bus.in_instr = 32'h12345037;
    bus.in_pc = 32'h204;
    step();
    bus.in_valid = 1'b0;
    chk("two_count", bus.count, 2);
    chk("two_in_ready", bus.in_ready, 0);
    chk("beq_type", bus.out_type, 9'b000100000);
    chk("beq_imm", bus.out_imm, 32'hFFFFFFFC);
    chk("beq_pc", bus.out_pc, 32'h200);
    step();
    chk("beq_stable_imm", bus.out_imm, 32'hFFFFFFFC);
    bus.out_ready = 1'b1;
    step();
    chk("lui_type", bus.out_type, 9'b010000000);
    chk("lui_imm", bus.out_imm, 32'h12345000);
    chk("lui_pc", bus.out_pc, 32'h204);
    chk("lui_count", bus.count, 1);

    // simultaneous push and pop: count holds, new entry follows
    bus.in_valid = 1'b1;
    bus.in_instr = addi(12'h7FF, 5'd3);
    bus.in_pc = 32'h208;
    step();
    bus.in_valid = 1'b0;
    chk("pushpop_count", bus.count, 1);
    chk("pushpop_pc", bus.out_pc, 32'h208);
    chk("pushpop_imm", bus.out_imm, 32'h7FF);
    step();
    chk("pushpop_drained", bus.count, 0);

    // 4: fill past DEPTH with out_ready low
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = addi(12'(i + 1), 5'd2);
      bus.in_pc = 32'h300 + 32'(4 * i);
      chk("fill_in_ready", bus.in_ready, (i < DEPTH) ? 1 : 0);
      step();
    end
    bus.in_valid = 1'b0;
    chk("full_count", bus.count, DEPTH);
    bus.out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_valid", bus.out_valid, 1);
      chk("drain_imm", bus.out_imm, 64'(i + 1));
      chk("drain_pc", bus.out_pc, 32'h300 + 32'(4 * i));
      step();
    end
    chk("drain_empty", bus.out_valid, 0);

    // 5: unknown opcode
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h0000000F;
    bus.in_pc = 32'h400;
    step();
    bus.in_valid = 1'b0;
    chk("unk_valid", bus.out_valid, 1);
    chk("unk_type", bus.out_type, 0);
    chk("unk_imm", bus.out_imm, 0);
`ifdef ILLEGAL_OPCODE_EN
    chk("unk_illegal", bus.out_illegal, 1);
`endif
    step();
    chk("unk_drained", bus.count, 0);

    // 6: flush with a full queue and in_valid high
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = addi(12'd7, 5'd4);
    step();
    bus.in_instr = addi(12'd8, 5'd4);
    step();
    chk("pre_flush_count", bus.count, 2);
    bus.flush = 1'b1;
    bus.in_instr = addi(12'd9, 5'd4);
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_count", bus.count, 0);
    chk("flush_valid", bus.out_valid, 0);
    step();
    chk("flush_stays_empty", bus.count, 0);

    // flush with room: the concurrent push must be discarded
    bus.in_valid = 1'b1;
    bus.in_instr = addi(12'd10, 5'd5);
    step();
    bus.flush = 1'b1;
    bus.in_instr = addi(12'd11, 5'd5);
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_push_count", bus.count, 0);
    chk("flush_push_valid", bus.out_valid, 0);

    // reset mid-stream drops entries
    bus.in_valid = 1'b1;
    bus.in_instr = addi(12'd12, 5'd6);
    step();
    bus.in_valid = 1'b0;
    chk("mid_count", bus.count, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_reset_count", bus.count, 0);
    chk("mid_reset_valid", bus.out_valid, 0);
    chk("mid_reset_ready", bus.in_ready, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
